// File: rtl/smem_pair_write_scheduler_pkg.sv
// Shared encodings and defaults for the SMEM paired-write scheduler.
// FSM states track how many result words the scheduler currently holds.
package smem_pair_write_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    PAIR = 2'd2
  } sched_state_e;

  localparam logic [64:0] DEFAULT_PAD_WORD = 65'h0;

endpackage

// File: rtl/smem_pair_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
// Produces no grant when disabled or when no lane requests.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LGW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [LGW-1:0]     last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int           idx_int;
  logic [LGW-1:0] idx;
  logic         found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_int = int'(last_grant_i) + off;
      if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
      idx = LGW'(idx_int);
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/smem_pair_write_scheduler.sv
// Merges lane result words into pairs for the 2-write/1-read FIFO port,
// padding a stranded word on flush or idle timeout and holding pairs while full.
module smem_pair_write_scheduler
  import smem_pair_write_scheduler_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 65,
  parameter int                    NUM_REQ       = 4,
  parameter int                    FLUSH_TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD      = DATA_WIDTH'(DEFAULT_PAD_WORD)
) (
  input  logic                          Clk,
  input  logic                          Clear_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic                          flush_in,
  output logic [DATA_WIDTH-1:0]         fifo_data_1_out,
  output logic [DATA_WIDTH-1:0]         fifo_data_2_out,
  output logic                          fifo_wr_en_out,
  input  logic                          fifo_full_in,
  output logic                          pending_out,
  output logic [15:0]                   pad_count_out
);

  localparam int             LGW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]     TIMEOUT_M1 = 8'(FLUSH_TIMEOUT - 1);

  sched_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]   slot_q, slot_d;
  logic [DATA_WIDTH-1:0]   data1_q, data1_d;
  logic [DATA_WIDTH-1:0]   data2_q, data2_d;
  logic [7:0]              idle_cnt_q, idle_cnt_d;
  logic [15:0]             pad_cnt_q, pad_cnt_d;
  logic [LGW-1:0]          last_grant_q, last_grant_d;

  logic                    wr_en;
  logic                    write_done;
  logic                    grant_en;
  logic [NUM_REQ-1:0]      grant;
  logic                    any_grant;
  logic [LGW-1:0]          grant_idx;
  logic [DATA_WIDTH-1:0]   grant_word;

  // Write request is the PAIR state itself, masked so nothing reaches the FIFO in a reset cycle.
  assign wr_en      = (state_q == PAIR) && !Clear_in;
  assign write_done = wr_en && !fifo_full_in;
  assign grant_en   = !Clear_in && ((state_q == IDLE) || (state_q == HALF) || write_done);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LGW     (LGW)
  ) u_arb (
    .req_i        (req_valid_in),
    .en_i         (grant_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    any_grant  = |grant;
    grant_idx  = '0;
    grant_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = LGW'(i);
        grant_word = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    idle_cnt_d   = idle_cnt_q;
    pad_cnt_d    = pad_cnt_q;
    last_grant_d = any_grant ? grant_idx : last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          state_d    = HALF;
          slot_d     = grant_word;
          idle_cnt_d = '0;
        end
      end
      HALF: begin
        // A real word always beats padding when both are possible.
        if (any_grant) begin
          state_d = PAIR;
          data1_d = slot_q;
          data2_d = grant_word;
        end else if (flush_in || (idle_cnt_q == TIMEOUT_M1)) begin
          state_d = PAIR;
          data1_d = slot_q;
          data2_d = PAD_WORD;
          if (pad_cnt_q != 16'hFFFF) pad_cnt_d = pad_cnt_q + 16'd1;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      PAIR: begin
        if (write_done) begin
          if (any_grant) begin
            state_d    = HALF;
            slot_d     = grant_word;
            idle_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      idle_cnt_q   <= '0;
      pad_cnt_q    <= '0;
      last_grant_q <= LGW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      idle_cnt_q   <= idle_cnt_d;
      pad_cnt_q    <= pad_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready_out   = grant;
  assign fifo_data_1_out = data1_q;
  assign fifo_data_2_out = data2_q;
  assign fifo_wr_en_out  = wr_en;
  assign pending_out     = (state_q != IDLE);
  assign pad_count_out   = pad_cnt_q;

endmodule

// File: tb/tb_smem_pair_write_scheduler.sv
// Bench for smem_pair_write_scheduler: per-cycle vector table plus hand-written
// timeout, flush-vs-grant, full-hold and mid-operation reset sequences.
module tb_smem_pair_write_scheduler;

  localparam int          DW   = 65;
  localparam int          NR   = 4;
  localparam int          FT   = 4;
  localparam logic [DW-1:0] PADW = 65'h1_5A5A_5A5A_5A5A_5A5A;

  logic             clk;
  logic             clear;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             flush;
  logic [DW-1:0]    d1, d2;
  logic             wr_en;
  logic             full;
  logic             pending;
  logic [15:0]      pad_cnt;

  logic [DW-1:0]    lane_word [NR];
  logic [2*DW-1:0]  exp_q [$];
  logic [DW-1:0]    hold_q [$];

  int tests_run    = 0;
  int tests_failed = 0;

  smem_pair_write_scheduler #(
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .FLUSH_TIMEOUT (FT),
    .PAD_WORD      (PADW)
  ) dut (
    .Clk             (clk),
    .Clear_in        (clear),
    .req_valid_in    (req_valid),
    .req_data_in     (req_data),
    .req_ready_out   (req_ready),
    .flush_in        (flush),
    .fifo_data_1_out (d1),
    .fifo_data_2_out (d2),
    .fifo_wr_en_out  (wr_en),
    .fifo_full_in    (full),
    .pending_out     (pending),
    .pad_count_out   (pad_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NR-1:0] v, input logic f, input logic fl);
    req_valid = v;
    flush     = f;
    full      = fl;
    for (int i = 0; i < NR; i++) begin
      lane_word[i] = {1'($urandom), $urandom, $urandom};
      req_data[i*DW +: DW] = lane_word[i];
    end
  endtask

  task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (wr_en && !full) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pair_write: got unexpected write %h/%h required no write", d1, d2);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        if ({d1, d2} !== e) begin
          tests_failed++;
          $display("FAIL pair_write: got %h/%h required %h/%h", d1, d2, e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [NR-1:0] valid;
    logic          flush;
    logic          full;
    logic          pad;
    logic [NR-1:0] exp_ready;
    logic          exp_wr;
    logic          exp_pend;
    logic [15:0]   exp_pcnt;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic [NR-1:0] v, input logic f, input logic fl, input logic p,
                              input logic [NR-1:0] r, input logic w, input logic pe, input logic [15:0] c);
    vec_t t;
    t.valid = v; t.flush = f; t.full = fl; t.pad = p;
    t.exp_ready = r; t.exp_wr = w; t.exp_pend = pe; t.exp_pcnt = c;
    return t;
  endfunction

  logic [DW-1:0] wa, wb, wc;
  int            lat;

  initial begin
    vecs[0]  = mk(4'b1111, 0, 0, 0, 4'b0001, 0, 0, 0);
    vecs[1]  = mk(4'b1110, 0, 0, 0, 4'b0010, 0, 1, 0);
    vecs[2]  = mk(4'b1100, 0, 0, 0, 4'b0100, 1, 1, 0);
    vecs[3]  = mk(4'b1000, 0, 0, 0, 4'b1000, 0, 1, 0);
    vecs[4]  = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 1, 0);
    vecs[5]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    vecs[6]  = mk(4'b1111, 0, 0, 0, 4'b0001, 0, 0, 0);
    vecs[7]  = mk(4'b1111, 0, 0, 0, 4'b0010, 0, 1, 0);
    vecs[8]  = mk(4'b1111, 0, 0, 0, 4'b0100, 1, 1, 0);
    vecs[9]  = mk(4'b1111, 0, 0, 0, 4'b1000, 0, 1, 0);
    vecs[10] = mk(4'b1111, 0, 0, 0, 4'b0001, 1, 1, 0);
    vecs[11] = mk(4'b0101, 0, 0, 0, 4'b0100, 0, 1, 0);
    vecs[12] = mk(4'b0001, 0, 1, 0, 4'b0000, 1, 1, 0);
    vecs[13] = mk(4'b0001, 0, 1, 0, 4'b0000, 1, 1, 0);
    vecs[14] = mk(4'b0001, 0, 0, 0, 4'b0001, 1, 1, 0);
    vecs[15] = mk(4'b0000, 1, 0, 1, 4'b0000, 0, 1, 0);
    vecs[16] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 1, 1);
    vecs[17] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1);
    vecs[18] = mk(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 1);
    vecs[19] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1);

    // Reset: grants suppressed even with every lane valid.
    clear = 1'b1;
    drive(4'b1111, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("reset_ready", req_ready, 0);
      chk("reset_wr_en", wr_en, 0);
      chk("reset_pending", pending, 0);
      chk("reset_pad_count", pad_cnt, 0);
      chk("reset_data", {d1, d2}, 0);
    end

    for (int r = 0; r < 20; r++) begin
      @(posedge clk); #1;
      clear = 1'b0;
      drive(vecs[r].valid, vecs[r].flush, vecs[r].full);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", r), req_ready, vecs[r].exp_ready);
      chk($sformatf("vec%0d_wr_en", r), wr_en, vecs[r].exp_wr);
      chk($sformatf("vec%0d_pending", r), pending, vecs[r].exp_pend);
      chk($sformatf("vec%0d_pad_count", r), pad_cnt, vecs[r].exp_pcnt);
      if (vecs[r].exp_ready != 0) hold_q.push_back(lane_word[onehot_idx(vecs[r].exp_ready)]);
      if (vecs[r].pad) hold_q.push_back(PADW);
      if (hold_q.size() == 2) begin
        exp_q.push_back({hold_q[0], hold_q[1]});
        hold_q.delete();
      end
    end

    // Lone word from lane 2 padded out by timeout.
    @(posedge clk); #1;
    drive(4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    chk("timeout_accept_ready", req_ready, 4'b0100);
    exp_q.push_back({lane_word[2], PADW});
    @(posedge clk); #1;
    drive(4'b0000, 1'b0, 1'b0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wr_en) begin
        lat = k;
        break;
      end
    end
    chk("timeout_latency", lat, FT + 1);
    chk("timeout_pad_count", pad_cnt, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("timeout_drained_pending", pending, 0);

    // Flush and grant in the same HALF cycle: grant wins, no pad.
    @(posedge clk); #1;
    drive(4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    chk("flushgrant_first_ready", req_ready, 4'b0010);
    wa = lane_word[1];
    @(posedge clk); #1;
    drive(4'b1000, 1'b1, 1'b0);
    @(negedge clk);
    chk("flushgrant_second_ready", req_ready, 4'b1000);
    chk("flushgrant_no_early_wr", wr_en, 0);
    exp_q.push_back({wa, lane_word[3]});
    @(posedge clk); #1;
    drive(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("flushgrant_wr_en", wr_en, 1);
    chk("flushgrant_pad_count", pad_cnt, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flushgrant_idle", pending, 0);

    // Pair held stable for 6 full cycles, then write plus same-cycle grant.
    @(posedge clk); #1;
    drive(4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_first_ready", req_ready, 4'b0001);
    wa = lane_word[0];
    @(posedge clk); #1;
    drive(4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_second_ready", req_ready, 4'b0010);
    wb = lane_word[1];
    exp_q.push_back({wa, wb});
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(4'b0100, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("full_hold%0d_wr_en", c), wr_en, 1);
      chk($sformatf("full_hold%0d_ready", c), req_ready, 0);
      chk($sformatf("full_hold%0d_data", c), {d1, d2}, {wa, wb});
    end
    @(posedge clk); #1;
    drive(4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_release_ready", req_ready, 4'b0100);
    wc = lane_word[2];
    @(posedge clk); #1;
    drive(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_release_half_pending", pending, 1);
    chk("full_release_half_wr_en", wr_en, 0);

    // Reset while HALF holds a word: the word is dropped, lane 0 wins next.
    @(posedge clk); #1;
    clear = 1'b1;
    drive(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("midreset_ready", req_ready, 0);
    chk("midreset_wr_en", wr_en, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    drive(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("midreset_pending", pending, 0);
    chk("midreset_pad_count", pad_cnt, 0);
    chk("midreset_next_grant", req_ready, 4'b0001);
    chk("midreset_dropped_word_differs", (lane_word[0] != wc), 1);
    exp_q.push_back({lane_word[0], PADW});
    @(posedge clk); #1;
    drive(4'b0000, 1'b0, 1'b0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (wr_en) begin
        lat = k;
        break;
      end
    end
    chk("midreset_timeout_latency", lat, FT + 1);
    chk("midreset_pad_after", pad_cnt, 1);

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_pending", pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
